// File: rtl/sdram_ahb_req_queue_if.sv
// Host request/response and AHB-style transfer signals of the SDRAM request queue.
// The slave modport is the queue's view; master is the host plus SDRAM-top side.
interface sdram_ahb_req_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              out_HSEL;
  logic              out_HWRITE;
  logic [ADDR_W-1:0] out_HADDR;
  logic [DATA_W-1:0] out_HWDATA;
  logic              in_HREADY;
  logic [DATA_W-1:0] in_HRDATA;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, in_HREADY, in_HRDATA,
    output req_ready, rsp_valid, rsp_rdata, out_HSEL, out_HWRITE, out_HADDR, out_HWDATA
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, in_HREADY, in_HRDATA,
    input  req_ready, rsp_valid, rsp_rdata, out_HSEL, out_HWRITE, out_HADDR, out_HWDATA
  );
endinterface

// File: rtl/sdram_ahb_req_queue.sv
// Request FIFO in front of the SDRAM top: replays queued reads/writes one at a time
// on the AHB-style port, returns read data on a valid/ready port, watchdogs HREADY.
module sdram_ahb_req_queue #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                          in_HCLK,
  input  logic                          in_HRESET,
  sdram_ahb_req_queue_if.slave          bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          err_timeout
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t            state, state_nx;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] mem_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data  [FIFO_DEPTH];
  logic              mem_write [FIFO_DEPTH];
  logic [WD_W-1:0]   wd_cnt;
  logic              full, empty, push, start, done, abort;

  assign full          = (count == CNT_W'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign bus.req_ready = !full;
  assign push          = bus.req_valid && !full;
  assign fifo_count    = count;
  assign busy          = (state != IDLE) || !empty;
  assign bus.out_HSEL  = (state == XFER);

  always_ff @(posedge in_HCLK or posedge in_HRESET) begin
    if (in_HRESET) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = XFER;
      XFER:    if (done || abort) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A read may only start once the response slot is free, so no read data is ever overwritten.
  always_comb begin
    start = 1'b0;
    done  = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE: start = !empty && !(!mem_write[rd_ptr] && bus.rsp_valid && !bus.rsp_ready);
      XFER: begin
        done  = bus.in_HREADY;
        abort = !bus.in_HREADY && (TIMEOUT != 0) && (wd_cnt == WD_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_HCLK) begin
    if (push) begin
      mem_addr[wr_ptr]  <= bus.req_addr;
      mem_data[wr_ptr]  <= bus.req_wdata;
      mem_write[wr_ptr] <= bus.req_write;
    end
  end

  always_ff @(posedge in_HCLK or posedge in_HRESET) begin
    if (in_HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (start) rd_ptr <= rd_ptr + 1'b1;
      case ({push, start})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_HCLK or posedge in_HRESET) begin
    if (in_HRESET) begin
      bus.out_HWRITE <= 1'b0;
      bus.out_HADDR  <= '0;
      bus.out_HWDATA <= '0;
      wd_cnt         <= '0;
      err_timeout    <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
    end else begin
      if (start) begin
        bus.out_HWRITE <= mem_write[rd_ptr];
        bus.out_HADDR  <= mem_addr[rd_ptr];
        bus.out_HWDATA <= mem_data[rd_ptr];
        wd_cnt         <= '0;
      end else if ((state == XFER) && !bus.in_HREADY) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (abort) err_timeout <= 1'b1;
      // A read completing on the same edge as a handshake keeps valid high with new data.
      if (done && !bus.out_HWRITE) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_rdata <= bus.in_HRDATA;
      end else if (bus.rsp_valid && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_ahb_req_queue.sv
// Directed bench for sdram_ahb_req_queue with a small SDRAM responder model and
// scoreboards for issued transfers and returned read data.
module tb_sdram_ahb_req_queue;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int TIMEOUT    = 255;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic busy, err_timeout;

  sdram_ahb_req_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) hif ();

  sdram_ahb_req_queue #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .in_HCLK(clk),
    .in_HRESET(rst),
    .bus(hif.slave),
    .fifo_count(fifo_count),
    .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  xfer_t       xfer_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] sdram [logic [31:0]];

  bit          stuck  = 1'b0;
  int unsigned wait_n = 0;
  int unsigned cyc = 0, xfer_cyc = 0, push_cyc = 0;
  int unsigned n_rise = 0, n_fall = 0, rise_cyc = 0, rise_gap = 0, fall_cyc = 0;
  int unsigned sel_len = 0, last_len = 0, rsp_rise_cyc = 0;
  bit          prev_sel = 1'b0, unstable = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
  logic [31:0] held = '0;
  xfer_t       cur, expx;
  bit          p_sel = 1'b0, p_rdy = 1'b0, p_wr = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitors and SDRAM responder; inputs from the stimulus change 1 time unit after posedge.
  always @(negedge clk) begin
    logic [31:0] r;
    cyc++;
    if (p_sel && p_rdy && p_wr) sdram[p_addr] = p_wdata;

    if (hif.out_HSEL && !prev_sel) begin
      n_rise++;
      rise_gap = cyc - rise_cyc;
      rise_cyc = cyc;
      sel_len  = 1;
      unstable = 1'b0;
      cur.w = hif.out_HWRITE;
      cur.a = hif.out_HADDR;
      cur.d = hif.out_HWDATA;
      if (xfer_q.size() == 0) begin
        chk("xfer_unexpected", {31'd0, hif.out_HWRITE, hif.out_HADDR}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        expx = xfer_q.pop_front();
        chk("xfer_write", hif.out_HWRITE, expx.w);
        chk("xfer_addr", hif.out_HADDR, expx.a);
        if (expx.w) chk("xfer_wdata", hif.out_HWDATA, expx.d);
      end
    end else if (hif.out_HSEL) begin
      sel_len++;
      if (hif.out_HWRITE !== cur.w || hif.out_HADDR !== cur.a || hif.out_HWDATA !== cur.d)
        unstable = 1'b1;
    end else if (prev_sel) begin
      n_fall++;
      fall_cyc = cyc;
      last_len = sel_len;
      chk("xfer_stable", unstable, 0);
    end
    prev_sel = hif.out_HSEL;

    if (hif.rsp_valid && !prev_rv) rsp_rise_cyc = cyc;
    if (hif.rsp_valid && prev_rv && !prev_rr) chk("rsp_hold", hif.rsp_rdata, held);
    if (hif.rsp_valid && hif.rsp_ready) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", {32'd0, hif.rsp_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_rdata", hif.rsp_rdata, r);
      end
    end
    prev_rv = hif.rsp_valid;
    prev_rr = hif.rsp_ready;
    held    = hif.rsp_rdata;

    if (hif.out_HSEL) xfer_cyc++;
    else              xfer_cyc = 0;
    hif.in_HREADY = !stuck && (hif.out_HSEL ? (xfer_cyc > wait_n) : (wait_n == 0));
    hif.in_HRDATA = sdram.exists(hif.out_HADDR) ? sdram[hif.out_HADDR] : '0;
    p_sel   = hif.out_HSEL;
    p_rdy   = hif.in_HREADY;
    p_wr    = hif.out_HWRITE;
    p_addr  = hif.out_HADDR;
    p_wdata = hif.out_HWDATA;
  end

  task automatic push(input bit w, input logic [31:0] a, input logic [31:0] d);
    int unsigned t = 0;
    xfer_t x;
    while (!hif.req_ready && t < 600) begin
      @(posedge clk); #1;
      t++;
    end
    if (!hif.req_ready) begin
      chk("push_ready_timeout", hif.req_ready, 1);
      return;
    end
    hif.req_valid = 1'b1;
    hif.req_write = w;
    hif.req_addr  = a;
    hif.req_wdata = d;
    x.w = w;
    x.a = a;
    x.d = d;
    xfer_q.push_back(x);
    @(posedge clk);
    push_cyc = cyc;
    #1;
    hif.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned max, input string name);
    int unsigned t = 0;
    while ((busy || hif.rsp_valid || xfer_q.size() != 0 || rsp_q.size() != 0) && t < max) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_drain_timeout"}, (t < max), 1);
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned n0, t;
    hif.req_valid = 1'b0;
    hif.req_write = 1'b0;
    hif.req_addr  = '0;
    hif.req_wdata = '0;
    hif.rsp_ready = 1'b1;

    // Reset state
    cycles(3);
    chk("rst_hsel", hif.out_HSEL, 0);
    chk("rst_hwrite", hif.out_HWRITE, 0);
    chk("rst_haddr", hif.out_HADDR, 0);
    chk("rst_hwdata", hif.out_HWDATA, 0);
    chk("rst_rsp_valid", hif.rsp_valid, 0);
    chk("rst_rsp_rdata", hif.rsp_rdata, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_req_ready", hif.req_ready, 1);
    rst = 1'b0;
    cycles(2);

    // 1: single write, HREADY tied high
    push(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    n0 = push_cyc;
    wait_idle(50, "t1");
    chk("t1_hsel_delay", rise_cyc - n0, 2);
    chk("t1_hsel_len", last_len, 1);

    // 2: read with 4 wait states
    wait_n = 4;
    rsp_q.push_back(32'hDEAD_BEEF);
    push(1'b0, 32'h0000_0010, 32'h0);
    wait_idle(50, "t2");
    chk("t2_hsel_len", last_len, 5);
    chk("t2_rsp_cycle", rsp_rise_cyc, fall_cyc);
    wait_n = 0;
    cycles(2);

    // 3: nine back-to-back requests against a stalled slave
    stuck = 1'b1;
    n0 = n_rise;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < 6) push(1'b1, 32'h100 + 4 * i, 32'hA000_0000 + i);
    end
    rsp_q.push_back(32'hA000_0001);
    push(1'b0, 32'h104, 32'h0);
    rsp_q.push_back(32'hA000_0003);
    push(1'b0, 32'h10C, 32'h0);
    rsp_q.push_back(32'hA000_0005);
    push(1'b0, 32'h114, 32'h0);
    chk("t3_count_full", fifo_count, 8);
    chk("t3_req_ready_full", hif.req_ready, 0);
    stuck = 1'b0;
    wait_idle(300, "t3");
    chk("t3_n_xfers", n_rise - n0, 9);
    chk("t3_xfer_period", rise_gap, 3);
    chk("t3_err", err_timeout, 0);

    // 4: two reads with the host stalling the response port
    hif.rsp_ready = 1'b0;
    n0 = n_rise;
    rsp_q.push_back(32'hA000_0001);
    push(1'b0, 32'h104, 32'h0);
    rsp_q.push_back(32'hA000_0003);
    push(1'b0, 32'h10C, 32'h0);
    t = 0;
    while (!hif.rsp_valid && t < 30) begin cycles(1); t++; end
    chk("t4_first_valid", hif.rsp_valid, 1);
    cycles(8);
    chk("t4_second_blocked", n_rise - n0, 1);
    chk("t4_hsel_low", hif.out_HSEL, 0);
    chk("t4_count", fifo_count, 1);
    hif.rsp_ready = 1'b1;
    cycles(1);
    hif.rsp_ready = 1'b0;
    t = 0;
    while (!hif.rsp_valid && t < 30) begin cycles(1); t++; end
    chk("t4_second_valid", hif.rsp_valid, 1);
    chk("t4_second_issued", n_rise - n0, 2);
    cycles(3);
    hif.rsp_ready = 1'b1;
    wait_idle(50, "t4");

    // 5: watchdog abort on a read, then a queued write proceeds
    stuck = 1'b1;
    n0 = n_fall;
    push(1'b0, 32'h104, 32'h0);
    push(1'b1, 32'h200, 32'h55AA_55AA);
    t = 0;
    while (n_fall == n0 && t < 400) begin cycles(1); t++; end
    chk("t5_abort_seen", (n_fall != n0), 1);
    chk("t5_hsel_len", last_len, 255);
    chk("t5_err", err_timeout, 1);
    stuck = 1'b0;
    rsp_q.push_back(32'h55AA_55AA);
    push(1'b0, 32'h200, 32'h0);
    wait_idle(100, "t5");
    chk("t5_err_sticky", err_timeout, 1);

    // 6: reset while a transfer is stalled with three entries queued
    stuck = 1'b1;
    for (int unsigned i = 0; i < 4; i++) push(1'b1, 32'h300 + 4 * i, 32'hC000_0000 + i);
    chk("t6_count", fifo_count, 3);
    chk("t6_hsel_active", hif.out_HSEL, 1);
    #2;
    rst = 1'b1;
    #1;
    xfer_q.delete();
    chk("t6_hsel_async", hif.out_HSEL, 0);
    chk("t6_count_rst", fifo_count, 0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_err_rst", err_timeout, 0);
    chk("t6_rsp_rst", hif.rsp_valid, 0);
    cycles(1);
    rst = 1'b0;
    stuck = 1'b0;
    n0 = n_rise;
    cycles(20);
    chk("t6_no_xfer", n_rise - n0, 0);
    chk("t6_busy_after", busy, 0);

    chk("end_xfer_q", xfer_q.size(), 0);
    chk("end_rsp_q", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at time %0t", $time);
    $fatal(1);
  end
endmodule
